// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the digit-serial BCD add/subtract unit.
package bcd_pkg;

   localparam int unsigned DIGIT_W       = 4;
   localparam logic        OP_ADD        = 1'b0;
   localparam logic        OP_SUB        = 1'b1;
   localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      NEGATE,
      DONE
   } state_e;

endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single-digit BCD stage: a_d + (sub ? 9-b_d : b_d) + cin with decimal correction.
module bcd_digit_addsub
   import bcd_pkg::*;
(
   input  logic [3:0] a_d,
   input  logic [3:0] b_d,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] s_d,
   output logic       cout
);

   logic [3:0] bd;
   logic [4:0] s;

   always_comb begin
      bd = sub ? (BCD_MAX_DIGIT - b_d) : b_d;
      s  = {1'b0, a_d} + {1'b0, bd} + {4'b0000, cin};
      if (s > {1'b0, BCD_MAX_DIGIT}) begin
         s_d  = 4'(s - 5'd10);
         cout = 1'b1;
      end else begin
         s_d  = s[3:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor (LSD first) returning signed magnitude.
// Define BCD_INPUT_CHECK_EN to reject operands containing non-BCD digits.
module bcd_addsub_serial
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  negative,
   output logic                  overflow,
   output logic                  error
);

   localparam int unsigned W        = DIGIT_W * DIGITS;
   localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_e           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     r_q, r_d;
   logic [W-1:0]     result_q, result_d;
   logic             op_q, op_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             negative_q, negative_d;
   logic             overflow_q, overflow_d;

   logic [3:0]       st_a, st_b, st_s;
   logic             st_cin, st_sub, st_cout;

`ifdef BCD_INPUT_CHECK_EN
   logic error_q, error_d;
   logic input_bad;

   always_comb begin
      input_bad = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (a[i*DIGIT_W +: DIGIT_W] > BCD_MAX_DIGIT ||
             b[i*DIGIT_W +: DIGIT_W] > BCD_MAX_DIGIT) begin
            input_bad = 1'b1;
         end
      end
   end
`endif

   bcd_digit_addsub u_digit (
      .a_d  (st_a),
      .b_d  (st_b),
      .cin  (st_cin),
      .sub  (st_sub),
      .s_d  (st_s),
      .cout (st_cout)
   );

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      r_d        = r_q;
      result_d   = result_q;
      op_d       = op_q;
      carry_d    = carry_q;
      idx_d      = idx_q;
      negative_d = negative_q;
      overflow_d = overflow_q;
`ifdef BCD_INPUT_CHECK_EN
      error_d    = error_q;
`endif
      st_a       = a_q[DIGIT_W-1:0];
      st_b       = b_q[DIGIT_W-1:0];
      st_cin     = carry_q;
      st_sub     = (op_q == OP_SUB);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               carry_d = op;
               idx_d   = '0;
               state_d = CALC;
`ifdef BCD_INPUT_CHECK_EN
               error_d = 1'b0;
               if (input_bad) begin
                  state_d    = DONE;
                  result_d   = {W{1'b1}};
                  error_d    = 1'b1;
                  negative_d = 1'b0;
                  overflow_d = 1'b0;
               end
`endif
            end
         end
         CALC: begin
            // r rotates in from the top so it is digit-aligned after DIGITS shifts
            a_d                  = a_q >> DIGIT_W;
            b_d                  = b_q >> DIGIT_W;
            r_d                  = r_q >> DIGIT_W;
            r_d[W-1 -: DIGIT_W]  = st_s;
            carry_d              = st_cout;
            idx_d                = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d = '0;
               if (op_q == OP_ADD) begin
                  result_d   = r_d;
                  overflow_d = st_cout;
                  negative_d = 1'b0;
                  state_d    = DONE;
               end else if (st_cout) begin
                  result_d   = r_d;
                  overflow_d = 1'b0;
                  negative_d = 1'b0;
                  state_d    = DONE;
               end else begin
                  carry_d = 1'b1;
                  state_d = NEGATE;
               end
            end
         end
         NEGATE: begin
            // ten's complement of the partial result: 0 - r
            st_a                 = '0;
            st_b                 = r_q[DIGIT_W-1:0];
            st_sub               = 1'b1;
            r_d                  = r_q >> DIGIT_W;
            r_d[W-1 -: DIGIT_W]  = st_s;
            carry_d              = st_cout;
            idx_d                = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d      = '0;
               result_d   = r_d;
               negative_d = 1'b1;
               overflow_d = 1'b0;
               state_d    = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= '0;
         result_q   <= '0;
         op_q       <= OP_ADD;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         negative_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         r_q        <= r_d;
         result_q   <= result_d;
         op_q       <= op_d;
         carry_q    <= carry_d;
         idx_q      <= idx_d;
         negative_q <= negative_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef BCD_INPUT_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   assign error = 1'b0;
`endif

   assign busy     = (state_q == CALC) || (state_q == NEGATE);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign negative = negative_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial (DIGITS = 4): vector table plus corner-case sequences.
module tb_bcd_addsub_serial;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic [15:0] a, b;
   logic        busy, done, negative, overflow, error;
   logic [15:0] result;

   int checks   = 0;
   int failures = 0;

   bcd_addsub_serial #(.DIGITS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .negative (negative),
      .overflow (overflow),
      .error    (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        neg;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs one operation; lat counts the cycle after the start edge as cycle 1.
   task automatic run_op(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                         output logic [15:0] res_o, output logic neg_o, output logic ovf_o,
                         output logic err_o, output int lat_o, output int busy_o,
                         output logic done_after, output logic [15:0] res_after);
      @(negedge clk);
      start = 1'b1;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      @(posedge clk);
      #1;
      start  = 1'b0;
      op     = ~op_i;
      a      = 16'h3141;
      b      = 16'h5926;
      lat_o  = 1;
      busy_o = 0;
      while (!done && lat_o < 40) begin
         if (busy) busy_o++;
         @(posedge clk);
         #1;
         lat_o++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL timeout: done not seen within %0d cycles", lat_o);
      end
      res_o = result;
      neg_o = negative;
      ovf_o = overflow;
      err_o = error;
      @(posedge clk);
      #1;
      done_after = done;
      res_after  = result;
   endtask

   logic [15:0] r, r2;
   logic        ng, ov, er, d2;
   int          lat, bc, cnt;

   initial begin
      vecs[0] = '{1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 5};
      vecs[1] = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b0, 1'b1, 5};
      vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 5};
      vecs[3] = '{1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 5};
      vecs[4] = '{1'b1, 16'h0777, 16'h0777, 16'h0000, 1'b0, 1'b0, 5};
      vecs[5] = '{1'b1, 16'h0100, 16'h0250, 16'h0150, 1'b1, 1'b0, 9};
      vecs[6] = '{1'b1, 16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9};
      vecs[7] = '{1'b0, 16'h5555, 16'h4445, 16'h0000, 1'b0, 1'b1, 5};

      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      #1;
      chk("reset_result", 32'(result), 32'h0);
      chk("reset_flags", {27'b0, busy, done, negative, overflow, error}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, ng, ov, er, lat, bc, d2, r2);
         chk($sformatf("v%0d_result", i), 32'(r), 32'(vecs[i].res));
         chk($sformatf("v%0d_negative", i), 32'(ng), 32'(vecs[i].neg));
         chk($sformatf("v%0d_overflow", i), 32'(ov), 32'(vecs[i].ovf));
         chk($sformatf("v%0d_error", i), 32'(er), 32'h0);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].lat - 1));
         chk($sformatf("v%0d_done_pulse", i), 32'(d2), 32'h0);
         chk($sformatf("v%0d_result_held", i), 32'(r2), 32'(vecs[i].res));
      end

      // start pulsed mid-operation must be ignored
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h5678;
      @(negedge clk);
      start = 1'b0; a = 16'h1111; b = 16'h1111;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (!done && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("ignored_start_done", 32'(done), 32'h1);
      chk("ignored_start_result", 32'(result), 32'h6912);
      @(negedge clk);
      @(negedge clk);
      chk("ignored_start_no_requeue", 32'(busy), 32'h0);

      // asynchronous reset at cycle 3 of an operation
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h5678;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midreset_result", 32'(result), 32'h0);
      chk("midreset_flags", {27'b0, busy, done, negative, overflow, error}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done || busy) cnt++;
      end
      chk("midreset_no_done", 32'(cnt), 32'h0);
      run_op(1'b0, 16'h0042, 16'h0058, r, ng, ov, er, lat, bc, d2, r2);
      chk("post_reset_result", 32'(r), 32'h0100);
      chk("post_reset_latency", 32'(lat), 32'd5);

      // non-BCD operand digit
      run_op(1'b0, 16'h12A4, 16'h0000, r, ng, ov, er, lat, bc, d2, r2);
`ifdef BCD_INPUT_CHECK_EN
      chk("badbcd_result", 32'(r), 32'hFFFF);
      chk("badbcd_error", 32'(er), 32'h1);
      chk("badbcd_latency", 32'(lat), 32'd1);
      chk("badbcd_flags", {30'b0, ng, ov}, 32'h0);
`else
      chk("badbcd_error", 32'(er), 32'h0);
      chk("badbcd_latency", 32'(lat), 32'd5);
`endif
      run_op(1'b1, 16'h0005, 16'h0003, r, ng, ov, er, lat, bc, d2, r2);
      chk("after_bad_error_clear", 32'(er), 32'h0);
      chk("after_bad_result", 32'(r), 32'h0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
